// File: rtl/doraemon_tx.sv
// doraemon_tx
//   Feeds the clk1-side record stream of the doraemon selector. The host pushes
//   records into a small FIFO, and the block sends them downstream. Each pattern
//   is 5 fill beats followed by PAT_NUM-1 streamed beats. After the last beat the
//   block parks in DONE and raises done.
//
// Ports
//   clk1, rst_n        clock, asynchronous active-low reset
//   start              one-cycle pulse, arms a pattern from IDLE/DONE
//   rec_valid/ready    host push handshake
//   rec_id..rec_ew     host record fields
//   ready              downstream ready (combinational on its side)
//   in_valid           registered record beat to downstream
//   doraemon_id..      registered record fields, zero when no beat
//   sent_cnt           beats issued in the current pattern
//   done               high while in DONE
module doraemon_tx #(
  parameter int PAT_NUM   = 5995,
  parameter int BUF_ASIZE = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rec_valid,
  output logic        rec_ready,
  input  logic [4:0]  rec_id,
  input  logic [7:0]  rec_size,
  input  logic [7:0]  rec_iq,
  input  logic [7:0]  rec_eq,
  input  logic [2:0]  rec_sw,
  input  logic [2:0]  rec_iw,
  input  logic [2:0]  rec_ew,
  input  logic        ready,
  output logic        in_valid,
  output logic [4:0]  doraemon_id,
  output logic [7:0]  size,
  output logic [7:0]  iq_score,
  output logic [7:0]  eq_score,
  output logic [2:0]  size_weight,
  output logic [2:0]  iq_weight,
  output logic [2:0]  eq_weight,
  output logic [13:0] sent_cnt,
  output logic        done
);

  localparam int          DEPTH      = 1 << BUF_ASIZE;
  localparam logic [13:0] LAST_BEAT  = 14'(PAT_NUM + 4);
  localparam logic [13:0] FILL_BEATS = 14'd5;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DONE} state_t;

  state_t state, state_nxt;

  logic [40:0]          mem [DEPTH];
  logic [BUF_ASIZE-1:0] wr_ptr, rd_ptr;
  logic [BUF_ASIZE:0]   count;
  logic [40:0]          rec_word, out_word;
  logic [13:0]          cnt_inc;
  logic                 active, full, empty, start_ok, push, pop;

  assign rec_word = {rec_id, rec_size, rec_iq, rec_eq, rec_sw, rec_iw, rec_ew};
  assign full     = (count == (BUF_ASIZE+1)'(DEPTH));
  assign empty    = (count == '0);
  assign active   = (state == S_FILL) || (state == S_STREAM);
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign rec_ready = active && !full;
  assign push     = rec_valid && rec_ready;
  // Fill beats never land in the downstream FIFO, so ready only gates streaming.
  assign pop      = active && !empty && ((state == S_FILL) || ready);
  assign cnt_inc  = sent_cnt + 14'd1;
  assign done     = (state == S_DONE);

  assign {doraemon_id, size, iq_score, eq_score,
          size_weight, iq_weight, eq_weight} = out_word;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // The phase changes on the edge that issues the boundary beat. With very
  // small PAT_NUM, the last beat can fall inside the fill phase.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_FILL;
      S_FILL: begin
        if (pop) begin
          if (cnt_inc == LAST_BEAT)       state_nxt = S_DONE;
          else if (cnt_inc == FILL_BEATS) state_nxt = S_STREAM;
        end
      end
      S_STREAM: if (pop && (cnt_inc == LAST_BEAT)) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Record storage has no reset. Validity is tracked only by the pointers.
  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= rec_word;
  end

  // A new pattern drops any records left over from the previous one.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start_ok) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The output stage is registered. The data lines carry zero whenever no beat is issued.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      in_valid <= 1'b0;
      out_word <= '0;
      sent_cnt <= '0;
    end else begin
      in_valid <= pop;
      out_word <= pop ? mem[rd_ptr] : '0;
      if (start_ok)  sent_cnt <= '0;
      else if (pop)  sent_cnt <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_doraemon_tx.sv
// tb_doraemon_tx
//   Randomized bench for doraemon_tx with PAT_NUM=8, which gives 12 beats per pattern.
//   A queue-based reference model tracks pattern progress and which host records must appear downstream.
module tb_doraemon_tx;

  localparam int PAT_NUM = 8;
  localparam int TOTAL   = PAT_NUM + 4;

  logic        clk1, rst_n, start, rec_valid, rec_ready, ready, in_valid, done;
  logic [4:0]  rec_id, doraemon_id;
  logic [7:0]  rec_size, rec_iq, rec_eq, size, iq_score, eq_score;
  logic [2:0]  rec_sw, rec_iw, rec_ew, size_weight, iq_weight, eq_weight;
  logic [13:0] sent_cnt;

  doraemon_tx #(.PAT_NUM(PAT_NUM), .BUF_ASIZE(2)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_id(rec_id), .rec_size(rec_size), .rec_iq(rec_iq), .rec_eq(rec_eq),
    .rec_sw(rec_sw), .rec_iw(rec_iw), .rec_ew(rec_ew),
    .ready(ready), .in_valid(in_valid),
    .doraemon_id(doraemon_id), .size(size), .iq_score(iq_score), .eq_score(eq_score),
    .size_weight(size_weight), .iq_weight(iq_weight), .eq_weight(eq_weight),
    .sent_cnt(sent_cnt), .done(done)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int checkCount = 0;
  int passCount  = 0;

  logic [40:0] modelQ[$];
  bit          modelActive = 0;
  bit          modelDone   = 0;
  int          modelSent   = 0;
  logic [2:0]  patSw, patIw, patEw;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
  endtask

  task automatic newWeights();
    patSw = 3'($urandom);
    patIw = 3'($urandom);
    patEw = 3'($urandom);
  endtask

  // One clock cycle: drive the inputs, step the model over the edge, then compare.
  task automatic applyStimulus(input int validPct, input int readyPct, input bit startPulse);
    logic [40:0] rec, expWord;
    bit          push, pop, expValid;
    @(negedge clk1);
    rec = {5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), patSw, patIw, patEw};
    {rec_id, rec_size, rec_iq, rec_eq, rec_sw, rec_iw, rec_ew} = rec;
    rec_valid = ($urandom_range(99) < validPct);
    ready     = ($urandom_range(99) < readyPct);
    start     = startPulse;
    #1;
    checkOutput("rec_ready", rec_ready, (modelActive && modelQ.size() < 4));
    push     = rec_valid && modelActive && (modelQ.size() < 4);
    pop      = modelActive && (modelQ.size() > 0) && ((modelSent < 5) || ready);
    expValid = 0;
    expWord  = '0;
    if (start && !modelActive) begin
      modelQ.delete();
      modelSent   = 0;
      modelDone   = 0;
      modelActive = 1;
    end else begin
      if (pop) begin
        expWord  = modelQ.pop_front();
        expValid = 1;
        modelSent++;
        if (modelSent == TOTAL) begin
          modelActive = 0;
          modelDone   = 1;
        end
      end
      if (push) modelQ.push_back(rec);
    end
    @(posedge clk1);
    #1;
    start = 1'b0;
    checkOutput("in_valid", in_valid, expValid);
    checkOutput("beat_data", {doraemon_id, size, iq_score, eq_score,
                              size_weight, iq_weight, eq_weight}, expWord);
    checkOutput("sent_cnt", sent_cnt, 14'(modelSent));
    checkOutput("done", done, modelDone);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_valid"}, in_valid, 1'b0);
    checkOutput({tag, "_rec_ready"}, rec_ready, 1'b0);
    checkOutput({tag, "_sent_cnt"}, sent_cnt, 14'd0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_data"}, {doraemon_id, size, iq_score, eq_score,
                                 size_weight, iq_weight, eq_weight}, 41'd0);
  endtask

  task automatic resetMid();
    @(negedge clk1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_rst");
    modelQ.delete();
    modelActive = 0;
    modelDone   = 0;
    modelSent   = 0;
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic runToDone(input int validPct, input int readyPct, input int startPct);
    int cyc = 0;
    while (!modelDone && cyc < 400) begin
      applyStimulus(validPct, readyPct, ($urandom_range(99) < startPct));
      cyc++;
    end
    checkOutput("pattern_done", done, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rec_valid = 1'b0; ready = 1'b0;
    {rec_id, rec_size, rec_iq, rec_eq, rec_sw, rec_iw, rec_ew} = '0;
    newWeights();
    repeat (2) @(negedge clk1);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    $display("[TB] back-to-back pattern");
    applyStimulus(100, 100, 1);
    repeat (20) applyStimulus(100, 100, 0);
    checkOutput("t1_done", done, 1'b1);

    $display("[TB] fill with ready low");
    newWeights();
    applyStimulus(100, 0, 1);
    repeat (10) applyStimulus(100, 0, 0);
    repeat (20) applyStimulus(100, 100, 0);

    $display("[TB] ready drop during stream, start ignored");
    newWeights();
    applyStimulus(100, 100, 1);
    repeat (7) applyStimulus(100, 100, 0);
    applyStimulus(100, 100, 1);
    repeat (3) applyStimulus(100, 0, 0);
    runToDone(100, 100, 0);

    $display("[TB] async reset mid stream");
    newWeights();
    applyStimulus(100, 100, 1);
    repeat (8) applyStimulus(100, 100, 0);
    resetMid();
    applyStimulus(100, 100, 1);
    runToDone(100, 100, 0);

    $display("[TB] random patterns");
    for (int p = 0; p < 20; p++) begin
      newWeights();
      applyStimulus(50, 50, 1);
      runToDone($urandom_range(100, 30), $urandom_range(100, 20), 5);
      repeat (3) applyStimulus(100, 100, 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
